// File: rtl/enc_update_ctrl.sv
// enc_update_ctrl: rotary-encoder and push-button front end for the OLED board.
// Conditions the raw lines, decodes detents into a wrapping cursor and schedules coalesced redraw requests.
`timescale 1ns/1ps
module enc_update_ctrl #(
   parameter int POS_MAX    = 19,
   parameter int DEB_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enc_a,
   input  logic       enc_b,
   input  logic       enc_btn,
   output logic [4:0] pos,
   output logic       dir_led,
   output logic       upd_req,
   input  logic       upd_ack,
   output logic [4:0] upd_pos,
   output logic       upd_press
);
   // state  | meaning
   // Q_IDLE | resting at a detent, A=B=1
   // Q_R1   | right turn: B has fallen
   // Q_R2   | right turn: A and B both low
   // Q_R3   | right turn: B back high, waiting for A to complete the step
   // Q_L1   | left turn: A has fallen
   // Q_L2   | left turn: A and B both low
   // Q_L3   | left turn: A back high, waiting for B to complete the step
   // S_IDLE | no request outstanding
   // S_REQ  | upd_req high, waiting for upd_ack
   // S_GAP  | one low cycle between requests

   typedef enum logic [2:0] {
      Q_IDLE = 3'd0,
      Q_R1   = 3'd1,
      Q_R2   = 3'd2,
      Q_R3   = 3'd3,
      Q_L1   = 3'd4,
      Q_L2   = 3'd5,
      Q_L3   = 3'd6
   } q_state_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_GAP  = 2'd2
   } s_state_t;

   localparam logic [4:0]  POS_TOP  = 5'(POS_MAX);
   localparam logic [16:0] DEB_TERM = 17'(DEB_CYCLES);
   // bit order {btn, b, a}: encoder lines idle high, button idles low
   localparam logic [2:0]  IN_RST   = 3'b011;

   logic [2:0]       raw;
   logic [2:0]       sync1;
   logic [2:0]       sync2;
   logic [2:0]       deb;
   logic [2:0]       deb_hit;
   logic [2:0][15:0] deb_cnt;
   logic             da;
   logic             db;
   logic             press;

   q_state_t q_st;
   q_state_t q_nxt;
   logic     step_up;
   logic     step_dn;
   logic     step;

   s_state_t s_st;
   s_state_t s_nxt;
   logic     load;
   logic     dirty;
   logic     press_pend;

   assign raw = {enc_btn, enc_b, enc_a};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= IN_RST;
         sync2 <= IN_RST;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   always_comb begin
      deb_hit = '0;
      for (int i = 0; i < 3; i++) begin
         deb_hit[i] = (sync2[i] != deb[i]) &&
                      (({1'b0, deb_cnt[i]} + 17'd1) == DEB_TERM);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb     <= IN_RST;
         deb_cnt <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (sync2[i] == deb[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_hit[i]) begin
               deb[i]     <= sync2[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + 16'd1;
            end
         end
      end
   end

   assign da    = deb[0];
   assign db    = deb[1];
   // button rising edge, taken on the same edge the debounced value flips
   assign press = deb_hit[2] & sync2[2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q_st <= Q_IDLE;
      else        q_st <= q_nxt;
   end

   always_comb begin
      q_nxt   = q_st;
      step_up = 1'b0;
      step_dn = 1'b0;
      case (q_st)
         Q_IDLE: begin
            if (!db)     q_nxt = Q_R1;
            else if (!da) q_nxt = Q_L1;
         end
         Q_R1: begin
            if (db)       q_nxt = Q_IDLE;
            else if (!da) q_nxt = Q_R2;
         end
         Q_R2: begin
            if (da)       q_nxt = Q_R1;
            else if (db)  q_nxt = Q_R3;
         end
         Q_R3: begin
            if (!db) begin
               q_nxt = Q_R2;
            end else if (da) begin
               q_nxt   = Q_IDLE;
               step_up = 1'b1;
            end
         end
         Q_L1: begin
            if (da)       q_nxt = Q_IDLE;
            else if (!db) q_nxt = Q_L2;
         end
         Q_L2: begin
            if (db)       q_nxt = Q_L1;
            else if (da)  q_nxt = Q_L3;
         end
         Q_L3: begin
            if (!da) begin
               q_nxt = Q_L2;
            end else if (db) begin
               q_nxt   = Q_IDLE;
               step_dn = 1'b1;
            end
         end
         default: q_nxt = Q_IDLE;
      endcase
   end

   assign step    = step_up | step_dn;
   assign dir_led = (q_st == Q_R1) || (q_st == Q_R2) || (q_st == Q_R3);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos <= '0;
      end else if (step_up) begin
         pos <= (pos == POS_TOP) ? 5'd0 : pos + 5'd1;
      end else if (step_dn) begin
         pos <= (pos == 5'd0) ? POS_TOP : pos - 5'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) s_st <= S_IDLE;
      else        s_st <= s_nxt;
   end

   // S_GAP reloads straight away when work is pending, so back-to-back
   // requests are separated by exactly one low cycle
   always_comb begin
      s_nxt = s_st;
      load  = 1'b0;
      case (s_st)
         S_IDLE: begin
            if (dirty || press_pend) begin
               load  = 1'b1;
               s_nxt = S_REQ;
            end
         end
         S_REQ: begin
            if (upd_ack) s_nxt = S_GAP;
         end
         S_GAP: begin
            if (dirty || press_pend) begin
               load  = 1'b1;
               s_nxt = S_REQ;
            end else begin
               s_nxt = S_IDLE;
            end
         end
         default: s_nxt = S_IDLE;
      endcase
   end

   assign upd_req = (s_st == S_REQ);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dirty      <= 1'b0;
         press_pend <= 1'b0;
         upd_pos    <= '0;
         upd_press  <= 1'b0;
      end else begin
         if (load) begin
            dirty      <= step;
            press_pend <= press;
            upd_pos    <= pos;
            upd_press  <= press_pend;
         end else begin
            dirty      <= dirty | step;
            press_pend <= press_pend | press;
         end
      end
   end

endmodule

// File: tb/tb_enc_update_ctrl.sv
// Testbench for enc_update_ctrl: table vectors, hand-written corner sequences
// and a randomized run against a transaction-level model of cursor and requests.
`timescale 1ns/1ps
module tb_enc_update_ctrl;
   localparam int POS_MAX = 19;
   localparam int DEB     = 4;
   localparam int NPOS    = POS_MAX + 1;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic       enc_a   = 1'b1;
   logic       enc_b   = 1'b1;
   logic       enc_btn = 1'b0;
   logic       upd_ack = 1'b0;
   logic [4:0] pos;
   logic [4:0] upd_pos;
   logic       dir_led;
   logic       upd_req;
   logic       upd_press;

   int n_cmp = 0;
   int n_err = 0;

   enc_update_ctrl #(.POS_MAX(POS_MAX), .DEB_CYCLES(DEB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enc_a     (enc_a),
      .enc_b     (enc_b),
      .enc_btn   (enc_btn),
      .pos       (pos),
      .dir_led   (dir_led),
      .upd_req   (upd_req),
      .upd_ack   (upd_ack),
      .upd_pos   (upd_pos),
      .upd_press (upd_press)
   );

   always #5 clk = ~clk;

   typedef enum int {OP_RIGHT, OP_LEFT, OP_PRESS, OP_GLITCH} op_t;
   typedef struct {
      op_t op;
      int  exp_pos;
      int  exp_press;
   } vec_t;

   vec_t vecs[8];

   // transaction-level model state
   int m_pos;
   bit out_req;
   int snap_pos;
   bit snap_press;
   bit pend_dirty;
   bit pend_press;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic phase(input logic a, input logic b, input int n);
      enc_a = a;
      enc_b = b;
      tick(n);
   endtask

   task automatic do_op(input op_t op);
      case (op)
         OP_RIGHT: begin
            phase(1, 0, 10); phase(0, 0, 10); phase(0, 1, 10); phase(1, 1, 10);
         end
         OP_LEFT: begin
            phase(0, 1, 10); phase(0, 0, 10); phase(1, 0, 10); phase(1, 1, 10);
         end
         OP_PRESS: begin
            enc_btn = 1'b1; tick(10);
            enc_btn = 1'b0; tick(10);
         end
         default: begin
            int len;
            len = $urandom_range(1, DEB - 1);
            if ($urandom_range(0, 1) == 1) phase(0, 1, len);
            else                           phase(1, 0, len);
            phase(1, 1, 10);
         end
      endcase
   endtask

   // serve an outstanding request with nothing pending behind it
   task automatic serve_simple(input int exp_pos, input int exp_press);
      check("srv_req", upd_req, 1);
      check("srv_pos", upd_pos, exp_pos);
      check("srv_press", upd_press, exp_press);
      upd_ack = 1'b1;
      tick(1);
      upd_ack = 1'b0;
      check("srv_drop", upd_req, 0);
      tick(3);
      check("srv_no_rereq", upd_req, 0);
   endtask

   task automatic model_op(input op_t op);
      bit ev_step;
      bit ev_press;
      ev_step  = 1'b0;
      ev_press = 1'b0;
      case (op)
         OP_RIGHT: begin m_pos = (m_pos + 1) % NPOS;        ev_step = 1'b1; end
         OP_LEFT:  begin m_pos = (m_pos + NPOS - 1) % NPOS; ev_step = 1'b1; end
         OP_PRESS: ev_press = 1'b1;
         default:  ;
      endcase
      if (ev_step || ev_press) begin
         if (!out_req) begin
            out_req    = 1'b1;
            snap_pos   = m_pos;
            snap_press = ev_press;
         end else begin
            pend_dirty = pend_dirty | ev_step;
            pend_press = pend_press | ev_press;
         end
      end
   endtask

   task automatic model_serve();
      check("rnd_srv_req", upd_req, 1);
      check("rnd_srv_pos", upd_pos, snap_pos);
      check("rnd_srv_press", upd_press, snap_press);
      upd_ack = 1'b1;
      tick(1);
      upd_ack = 1'b0;
      check("rnd_srv_drop", upd_req, 0);
      tick(1);
      if (pend_dirty || pend_press) begin
         snap_pos   = m_pos;
         snap_press = pend_press;
         pend_dirty = 1'b0;
         pend_press = 1'b0;
         out_req    = 1'b1;
         check("rnd_gap_req", upd_req, 1);
         check("rnd_gap_pos", upd_pos, snap_pos);
         check("rnd_gap_press", upd_press, snap_press);
      end else begin
         out_req = 1'b0;
         check("rnd_gap_idle", upd_req, 0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{OP_RIGHT, 1,  0};
      vecs[1] = '{OP_LEFT,  0,  0};
      vecs[2] = '{OP_LEFT,  19, 0};
      vecs[3] = '{OP_RIGHT, 0,  0};
      vecs[4] = '{OP_LEFT,  19, 0};
      vecs[5] = '{OP_LEFT,  18, 0};
      vecs[6] = '{OP_PRESS, 18, 1};
      vecs[7] = '{OP_RIGHT, 19, 0};

      // reset state
      tick(3);
      check("rst_pos", pos, 0);
      check("rst_req", upd_req, 0);
      check("rst_upd_pos", upd_pos, 0);
      check("rst_upd_press", upd_press, 0);
      check("rst_dir_led", dir_led, 0);
      rst_n = 1'b1;
      tick(30);
      check("idle_no_req", upd_req, 0);
      check("idle_pos", pos, 0);

      // table vectors: detents, wraps and a press, each served at once
      for (int i = 0; i < 8; i++) begin
         do_op(vecs[i].op);
         check("vec_pos", pos, vecs[i].exp_pos);
         serve_simple(vecs[i].exp_pos, vecs[i].exp_press);
      end

      // partial right rotation: direction LED on, no step on return
      phase(1, 0, 10);
      check("dir_led_on", dir_led, 1);
      phase(1, 1, 10);
      check("dir_led_off", dir_led, 0);
      check("partial_pos", pos, 19);
      check("partial_no_req", upd_req, 0);

      // short glitches on B never reach the decoder
      for (int k = 0; k < 3; k++) begin
         phase(1, 0, DEB - 1);
         phase(1, 1, 10);
         check("glitch_dir_led", dir_led, 0);
      end
      phase(1, 0, DEB + 1);
      phase(1, 1, 20);
      check("bounce_dir_led", dir_led, 0);
      check("bounce_pos", pos, 19);
      check("bounce_no_req", upd_req, 0);

      // coalescing: 3 detents and 2 presses behind an unacknowledged request
      do_op(OP_RIGHT);
      check("coal_first_req", upd_req, 1);
      check("coal_first_pos", upd_pos, 0);
      for (int k = 0; k < 5; k++) begin
         do_op((k % 2 == 1) ? OP_PRESS : OP_RIGHT);
         check("coal_hold_req", upd_req, 1);
         check("coal_hold_pos", upd_pos, 0);
         check("coal_hold_press", upd_press, 0);
      end
      check("coal_live_pos", pos, 3);
      upd_ack = 1'b1;
      tick(1);
      upd_ack = 1'b0;
      check("coal_gap", upd_req, 0);
      tick(1);
      check("coal_second_req", upd_req, 1);
      check("coal_second_pos", upd_pos, 3);
      check("coal_second_press", upd_press, 1);
      serve_simple(3, 1);

      // a step landing on the ack cycle
      do_op(OP_RIGHT);
      check("ackev_first_pos", upd_pos, 4);
      phase(1, 0, 10);
      phase(0, 0, 10);
      phase(0, 1, 10);
      enc_a = 1'b1;
      tick(2 + DEB);
      check("ackev_still_req", upd_req, 1);
      check("ackev_pre_pos", pos, 4);
      upd_ack = 1'b1;
      tick(1);
      upd_ack = 1'b0;
      check("ackev_step_pos", pos, 5);
      check("ackev_drop", upd_req, 0);
      tick(1);
      check("ackev_second_req", upd_req, 1);
      check("ackev_second_pos", upd_pos, 5);
      check("ackev_second_press", upd_press, 0);
      serve_simple(5, 0);

      // randomized operations against the model
      m_pos      = 5;
      out_req    = 1'b0;
      snap_pos   = 0;
      snap_press = 1'b0;
      pend_dirty = 1'b0;
      pend_press = 1'b0;
      for (int it = 0; it < 30; it++) begin
         op_t op;
         op = op_t'($urandom_range(0, 3));
         do_op(op);
         model_op(op);
         check("rnd_pos", pos, m_pos);
         check("rnd_req", upd_req, out_req);
         if (out_req) begin
            check("rnd_upd_pos", upd_pos, snap_pos);
            check("rnd_upd_press", upd_press, snap_press);
         end
         if (out_req && $urandom_range(0, 2) == 0) model_serve();
      end
      for (int k = 0; k < 3; k++) begin
         if (out_req) model_serve();
      end
      tick(3);
      check("rnd_drained", upd_req, 0);

      // reset in the middle of an outstanding request
      do_op(OP_RIGHT);
      check("mid_req_up", upd_req, 1);
      rst_n = 1'b0;
      #2;
      check("mid_rst_req", upd_req, 0);
      check("mid_rst_pos", pos, 0);
      check("mid_rst_upd_pos", upd_pos, 0);
      check("mid_rst_dir_led", dir_led, 0);
      tick(2);
      rst_n = 1'b1;
      tick(30);
      check("post_rst_no_req", upd_req, 0);
      check("post_rst_pos", pos, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
